// File: rtl/fft_mem_arb_pkg.sv
// Shared types for the FFT memory-port arbiter: FSM states, requester ids
// and the read-return tag carried through the latency pipe.
package fft_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OWN_ENG  = 2'd1,
      OWN_HOST = 2'd2
   } arb_state_e;

   localparam int REQ_ENG  = 0;
   localparam int REQ_HOST = 1;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

   function automatic logic [1:0] id2onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/fft_mem_rd_tag_pipe.sv
// RD_LAT-deep shift pipe of read tags; the last stage lines up with the
// memory's read data and is decoded to a per-requester valid strobe.
module fft_mem_rd_tag_pipe
   import fft_mem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  rd_tag_t    push_i,
   output logic [1:0] rvalid_o,
   output logic       any_valid_o
);

   rd_tag_t r_pipe [RD_LAT];

   // shift tags toward the output, clearing everything on reset
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_pipe[i] <= rd_tag_t'(2'b00);
         end
      end else begin
         r_pipe[0] <= push_i;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   // any in-flight read and output decode
   always_comb begin
      any_valid_o = 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
         any_valid_o = any_valid_o | r_pipe[i].valid;
      end
      if (r_pipe[RD_LAT-1].valid) begin
         rvalid_o = id2onehot(r_pipe[RD_LAT-1].id);
      end else begin
         rvalid_o = 2'b00;
      end
   end

endmodule

// File: rtl/fft_mem_arbiter.sv
// Two-requester (engine/host) arbiter for the FFT single-port memory with
// round-robin, burst lock and read routing. Optional counters: ARB_PERF_EN.
module fft_mem_arbiter
   import fft_mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 16
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic [1:0]          req_i,
   input  logic [1:0]          lock_i,
   input  logic [1:0]          we_i,
   input  logic [2*ADDR_W-1:0] addr_i,
   input  logic [2*DATA_W-1:0] wdata_i,
   output logic [1:0]          gnt_o,
   output logic [1:0]          rvalid_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_data_o,
   output logic                mem_write_o,
   output logic                mem_valid_o,
   input  logic [DATA_W-1:0]   mem_data_i,
   input  logic                mem_ready_i,
   output logic                busy_o
`ifdef ARB_PERF_EN
   ,
   input  logic                perf_clr_i,
   output logic [31:0]         perf_gnt_cnt_o,
   output logic [31:0]         perf_wait_cnt_o
`endif
);

   localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

   arb_state_e r_state;
   logic       r_rr_ptr;
   logic [7:0] r_burst_cnt;

   logic       w_sel;
   logic [1:0] w_gnt;
   logic       w_acc;
   logic [7:0] w_cnt_nxt;
   logic       w_rd_busy;
   rd_tag_t    w_push;

   // grant selection: owner while locked, else the lone requester or RR pointer
   always_comb begin
      case (r_state)
         IDLE: begin
            if (req_i == 2'b11) begin
               w_sel = r_rr_ptr;
            end else begin
               w_sel = req_i[REQ_HOST];
            end
         end
         OWN_ENG:  w_sel = 1'b0;
         OWN_HOST: w_sel = 1'b1;
         default:  w_sel = 1'b0;
      endcase
      if (reset_n_i) begin
         w_gnt = id2onehot(w_sel) & req_i;
      end else begin
         w_gnt = 2'b00;
      end
   end

   assign gnt_o       = w_gnt;
   assign mem_valid_o = |w_gnt;
   assign w_acc       = mem_valid_o & mem_ready_i;
   assign w_cnt_nxt   = r_burst_cnt + 8'd1;
   assign mem_write_o = mem_valid_o & we_i[w_sel];
   assign mem_addr_o  = !mem_valid_o ? '0 :
                        (w_sel ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0]);
   assign mem_data_o  = !mem_valid_o ? '0 :
                        (w_sel ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0]);

   assign w_push.valid = w_acc & ~we_i[w_sel];
   assign w_push.id    = w_sel;

   // arbitration FSM; nothing moves while memory is stalled
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= IDLE;
         r_rr_ptr    <= 1'b0;
         r_burst_cnt <= 8'd0;
      end else if (mem_ready_i) begin
         case (r_state)
            IDLE: begin
               if (w_acc && lock_i[w_sel]) begin
                  r_state     <= w_sel ? OWN_HOST : OWN_ENG;
                  r_burst_cnt <= 8'd1;
               end else if (w_acc) begin
                  r_rr_ptr <= ~w_sel;
               end
            end
            OWN_ENG, OWN_HOST: begin
               // no accept with memory ready means the owner dropped req
               if (!w_acc || !lock_i[w_sel] || w_cnt_nxt == MAX_BURST_C) begin
                  r_state     <= IDLE;
                  r_rr_ptr    <= ~w_sel;
                  r_burst_cnt <= 8'd0;
               end else begin
                  r_burst_cnt <= w_cnt_nxt;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_burst_cnt <= 8'd0;
            end
         endcase
      end
   end

   fft_mem_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .push_i      (w_push),
      .rvalid_o    (rvalid_o),
      .any_valid_o (w_rd_busy)
   );

   assign rdata_o = (|rvalid_o) ? mem_data_i : '0;
   assign busy_o  = w_rd_busy | (r_state != IDLE);

`ifdef ARB_PERF_EN
   logic [15:0] r_perf_gnt  [2];
   logic [15:0] r_perf_wait [2];

   // saturating per-requester accept and wait-cycle counters
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int k = 0; k < 2; k++) begin
            r_perf_gnt[k]  <= 16'd0;
            r_perf_wait[k] <= 16'd0;
         end
      end else if (perf_clr_i) begin
         for (int k = 0; k < 2; k++) begin
            r_perf_gnt[k]  <= 16'd0;
            r_perf_wait[k] <= 16'd0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (w_acc && (w_sel == 1'(k))) begin
               if (r_perf_gnt[k] != 16'hFFFF) r_perf_gnt[k] <= r_perf_gnt[k] + 16'd1;
            end else if (req_i[k]) begin
               if (r_perf_wait[k] != 16'hFFFF) r_perf_wait[k] <= r_perf_wait[k] + 16'd1;
            end
         end
      end
   end

   assign perf_gnt_cnt_o  = {r_perf_gnt[1], r_perf_gnt[0]};
   assign perf_wait_cnt_o = {r_perf_wait[1], r_perf_wait[0]};
`endif

endmodule

// File: tb/tb_fft_mem_arbiter.sv
// Directed bench for fft_mem_arbiter (RD_LAT = 3, MAX_BURST = 16) with a
// small behavioural memory behind the arbiter port.
module tb_fft_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int RL = 3;

   logic            clk_i = 1'b0;
   logic            reset_n_i;
   logic [1:0]      req_i, lock_i, we_i;
   logic [2*AW-1:0] addr_i;
   logic [2*DW-1:0] wdata_i;
   logic [1:0]      gnt_o, rvalid_o;
   logic [DW-1:0]   rdata_o, mem_data_o, mem_data_i;
   logic [AW-1:0]   mem_addr_o;
   logic            mem_write_o, mem_valid_o, mem_ready_i, busy_o;
`ifdef ARB_PERF_EN
   logic            perf_clr_i;
   logic [31:0]     perf_gnt_cnt_o, perf_wait_cnt_o;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   fft_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_BURST(16)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .req_i(req_i), .lock_i(lock_i),
      .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_write_o(mem_write_o), .mem_valid_o(mem_valid_o),
      .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i), .busy_o(busy_o)
`ifdef ARB_PERF_EN
      , .perf_clr_i(perf_clr_i), .perf_gnt_cnt_o(perf_gnt_cnt_o),
      .perf_wait_cnt_o(perf_wait_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // memory model: writes land on accept, reads return RL cycles later
   logic [DW-1:0] mem [16];
   logic [DW-1:0] rd_pipe [RL];
   always @(posedge clk_i) begin
      if (mem_valid_o && mem_ready_i && mem_write_o) mem[mem_addr_o[3:0]] <= mem_data_o;
      rd_pipe[0] <= mem[mem_addr_o[3:0]];
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_data_i = rd_pipe[RL-1];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int eng_cnt;
      int bad_rv;
      reset_n_i = 1'b0; req_i = 2'b11; lock_i = 2'b00; we_i = 2'b00;
      addr_i = '0; wdata_i = '0; mem_ready_i = 1'b1;
`ifdef ARB_PERF_EN
      perf_clr_i = 1'b0;
`endif
      #2;
      check("rst_gnt", gnt_o, 2'b00);
      check("rst_mem_valid", mem_valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_rvalid", rvalid_o, 2'b00);
      check("rst_rdata", rdata_o, 32'h0);
      tick(); tick();
      reset_n_i = 1'b1; req_i = 2'b00;

      // round robin between two continuous writers
      req_i = 2'b11; we_i = 2'b11;
      addr_i = {16'h0002, 16'h0001}; wdata_i = {32'h2222_2222, 32'h1111_1111};
      #2;
      check("rr1_gnt", gnt_o, 2'b01);
      check("rr1_addr", mem_addr_o, 16'h0001);
      check("rr1_data", mem_data_o, 32'h1111_1111);
      check("rr1_write", mem_write_o, 1'b1);
      tick(); #2;
      check("rr2_gnt", gnt_o, 2'b10);
      check("rr2_addr", mem_addr_o, 16'h0002);
      tick(); #2;
      check("rr3_gnt", gnt_o, 2'b01);
      tick(); #2;
      check("rr4_gnt", gnt_o, 2'b10);
      check("rr4_busy", busy_o, 1'b0);
      tick();

      // engine writes, host reads it back
      req_i = 2'b01; we_i = 2'b01; addr_i = {16'h0000, 16'h0000};
      wdata_i = {32'h0, 32'hA5A5_A5A5};
      #2;
      check("ewr_gnt", gnt_o, 2'b01);
      check("ewr_data", mem_data_o, 32'hA5A5_A5A5);
      tick();
      req_i = 2'b10; we_i = 2'b00;
      #2;
      check("hrd_gnt", gnt_o, 2'b10);
      check("hrd_write", mem_write_o, 1'b0);
      tick();
      req_i = 2'b00;
      #2;
      check("hrd_lat1_rvalid", rvalid_o, 2'b00);
      check("hrd_lat1_busy", busy_o, 1'b1);
      tick(); #2;
      check("hrd_lat2_rvalid", rvalid_o, 2'b00);
      tick(); #2;
      check("hrd_ret_rvalid", rvalid_o, 2'b10);
      check("hrd_ret_rdata", rdata_o, 32'hA5A5_A5A5);
      tick(); #2;
      check("hrd_after_rvalid", rvalid_o, 2'b00);
      check("hrd_after_busy", busy_o, 1'b0);
      tick();

      // engine burst lock against a waiting host
      req_i = 2'b11; lock_i = 2'b01; we_i = 2'b11;
      eng_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         #2;
         if (gnt_o == 2'b01) eng_cnt++;
         if (i == 5) check("burst_busy", busy_o, 1'b1);
         tick();
      end
      check("burst_eng_grants", 64'(eng_cnt), 64'd16);
      #2;
      check("burst_17_gnt", gnt_o, 2'b10);
      check("burst_17_busy", busy_o, 1'b0);
      tick();
      req_i = 2'b00; lock_i = 2'b00;

      // memory stall during a host read; RR pointer must not move
      req_i = 2'b01; we_i = 2'b01; addr_i = {16'h0002, 16'h0003};
      wdata_i = {32'h0, 32'h3333_3333};
      #2;
      check("stall_pre_gnt", gnt_o, 2'b01);
      tick();
      req_i = 2'b10; we_i = 2'b00; mem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("stall_gnt", gnt_o, 2'b10);
         check("stall_rvalid", rvalid_o, 2'b00);
         tick();
      end
      mem_ready_i = 1'b1; req_i = 2'b11; we_i = 2'b01;
      #2;
      check("stall_accept_gnt", gnt_o, 2'b10);
      tick();
      req_i = 2'b01;
      #2;
      check("stall_next_gnt", gnt_o, 2'b01);
      tick();
      req_i = 2'b00;
      #2;
      check("stall_lat2_rvalid", rvalid_o, 2'b00);
      tick(); #2;
      check("stall_ret_rvalid", rvalid_o, 2'b10);
      check("stall_ret_rdata", rdata_o, 32'h2222_2222);
      tick();

      // reset with an engine read in flight
      req_i = 2'b01; we_i = 2'b00; addr_i = {16'h0000, 16'h0001};
      #2;
      check("rstfl_gnt", gnt_o, 2'b01);
      tick();
      req_i = 2'b00;
      #2;
      check("rstfl_busy", busy_o, 1'b1);
      reset_n_i = 1'b0; req_i = 2'b11;
      #1;
      check("rstfl_busy0", busy_o, 1'b0);
      check("rstfl_gnt0", gnt_o, 2'b00);
      check("rstfl_rvalid0", rvalid_o, 2'b00);
      check("rstfl_memvalid0", mem_valid_o, 1'b0);
      tick(); tick();
      reset_n_i = 1'b1; req_i = 2'b00;
      bad_rv = 0;
      for (int i = 0; i < 4; i++) begin
         #2;
         if (rvalid_o != 2'b00) bad_rv++;
         tick();
      end
      check("rstfl_no_rvalid", 64'(bad_rv), 64'd0);
      req_i = 2'b11; we_i = 2'b11;
      #2;
      check("rstfl_rr_reset", gnt_o, 2'b01);
      tick();
      req_i = 2'b00; we_i = 2'b00;

`ifdef ARB_PERF_EN
      perf_clr_i = 1'b1;
      tick();
      perf_clr_i = 1'b0;
      req_i = 2'b10; we_i = 2'b10; mem_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      mem_ready_i = 1'b1;
      tick(); tick();
      req_i = 2'b00;
      #2;
      check("perf_wait_host", perf_wait_cnt_o[31:16], 16'd5);
      check("perf_gnt_host", perf_gnt_cnt_o[31:16], 16'd2);
      check("perf_gnt_eng", perf_gnt_cnt_o[15:0], 16'd0);
      tick();
      perf_clr_i = 1'b1;
      tick();
      perf_clr_i = 1'b0;
      #2;
      check("perf_clr_gnt", perf_gnt_cnt_o, 32'd0);
      check("perf_clr_wait", perf_wait_cnt_o, 32'd0);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
